// File: rtl/serial_adder_sequencer.sv
// rtl/serial_adder_sequencer.sv - bit-serial add/subtract sequencer, LSB first
// Two half adders plus a carry OR form the only arithmetic cell; the FSM feeds it one bit per clock.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
  half_adder u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

  assign c_o = c0 | c1;
endmodule

module serial_adder_sequencer #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic             in_ready_q, busy_q, out_valid_q;
  logic             s_bit, c_next;
  logic [WIDTH-1:0] res_d;

  full_adder u_fa (
    .a_i(a_sh_q[0]),
    .b_i(b_sh_q[0]),
    .c_i(carry_q),
    .s_o(s_bit),
    .c_o(c_next)
  );

  assign res_d = {s_bit, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1; cin has no meaning for subtraction.
            a_sh_q     <= a;
            b_sh_q     <= sub ? ~b : b;
            carry_q    <= sub | cin;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          res_q   <= res_d;
          carry_q <= c_next;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // carry_q is the carry into the MSB on this final step.
            sum_q       <= res_d;
            cout_q      <= c_next;
            ovf_q       <= carry_q ^ c_next;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder_sequencer.sv
// tb/tb_serial_adder_sequencer.sv - self-checking bench for serial_adder_sequencer
// Drives a WIDTH=4 and a WIDTH=8 instance through one shared operand bus; sel picks the active one.

module tb_serial_adder_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        iv, ordy;
  logic [31:0] a_r, b_r;
  logic        cin_r, sub_r;

  logic       ir4, bz4, ov4, co4, vf4;
  logic [3:0] sum4;
  logic       ir8, bz8, ov8, co8, vf8;
  logic [7:0] sum8;

  logic        c_ir, c_bz, c_ov, c_co, c_vf;
  logic [31:0] c_sum;

  int n_checks = 0;
  int n_fail = 0;
  int n_issued = 0;
  int n_presented = 0;
  logic ov_prev = 1'b0;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        co, ov;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  serial_adder_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv & ~sel), .in_ready(ir4),
    .a(a_r[3:0]), .b(b_r[3:0]), .cin(cin_r), .sub(sub_r),
    .busy(bz4), .out_valid(ov4), .out_ready(ordy & ~sel),
    .sum(sum4), .cout(co4), .ovf(vf4)
  );

  serial_adder_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv & sel), .in_ready(ir8),
    .a(a_r[7:0]), .b(b_r[7:0]), .cin(cin_r), .sub(sub_r),
    .busy(bz8), .out_valid(ov8), .out_ready(ordy & sel),
    .sum(sum8), .cout(co8), .ovf(vf8)
  );

  assign c_ir  = sel ? ir8 : ir4;
  assign c_bz  = sel ? bz8 : bz4;
  assign c_ov  = sel ? ov8 : ov4;
  assign c_co  = sel ? co8 : co4;
  assign c_vf  = sel ? vf8 : vf4;
  assign c_sum = sel ? {24'b0, sum8} : {28'b0, sum4};

  // Every rising edge of out_valid is one presented result, independent of the driver tasks.
  always @(negedge clk) begin
    if ((ov4 | ov8) && !ov_prev) n_presented++;
    ov_prev = ov4 | ov8;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input int w, input longint ua, input longint ub,
                                    input bit c, input bit s,
                                    output longint rs, output bit rc, output bit rv);
    longint m, raw, sa, sb, r;
    m   = longint'(1) << w;
    raw = s ? ua - ub : ua + ub + longint'(c);
    rs  = ((raw % m) + m) % m;
    rc  = s ? (ua >= ub) : (raw >= m);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sb  = (ub >= m / 2) ? ub - m : ub;
    r   = s ? sa - sb : sa + sb + longint'(c);
    rv  = (r >= m / 2) || (r < -(m / 2));
  endfunction

  // Starts and ends 1 time unit after a rising edge.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc, input logic os,
                        input int pre, input int post,
                        output logic [31:0] rs, output logic rc, output logic rv);
    int w;
    int n;
    logic [31:0] prev;
    w = sel ? 8 : 4;
    repeat (pre) @(posedge clk);
    #1;
    prev = c_sum;
    chk("in_ready_idle", c_ir, 1);
    a_r = oa; b_r = ob; cin_r = oc; sub_r = os; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    a_r = $urandom; b_r = $urandom; cin_r = 1'($urandom); sub_r = 1'($urandom);
    n_issued++;
    n = 0;
    while (!c_ov && n < 64) begin
      chk("busy_run", c_bz, 1);
      chk("in_ready_run", c_ir, 0);
      chk("sum_hold_run", c_sum, prev);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, w);
    chk("busy_done", c_bz, 0);
    rs = c_sum; rc = c_co; rv = c_vf;
    repeat (post) begin
      ordy = 1'b0;
      @(posedge clk); #1;
      chk("out_valid_stall", c_ov, 1);
      chk("sum_stall", c_sum, rs);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("out_valid_after_hs", c_ov, 0);
    chk("in_ready_after_hs", c_ir, 1);
  endtask

  initial begin
    logic [31:0] rs;
    logic        rc, rv;
    longint      es;
    bit          ec, ev;
    int          w;
    int          n;

    tbl[0] = '{a: 5,  b: 3, cin: 0, sub: 0, s: 8,  co: 0, ov: 1};
    tbl[1] = '{a: 15, b: 1, cin: 0, sub: 0, s: 0,  co: 1, ov: 0};
    tbl[2] = '{a: 2,  b: 2, cin: 1, sub: 0, s: 5,  co: 0, ov: 0};
    tbl[3] = '{a: 3,  b: 5, cin: 0, sub: 1, s: 14, co: 0, ov: 0};
    tbl[4] = '{a: 7,  b: 8, cin: 0, sub: 1, s: 15, co: 0, ov: 1};
    tbl[5] = '{a: 6,  b: 6, cin: 1, sub: 1, s: 0,  co: 1, ov: 0};

    sel = 1'b0; iv = 1'b0; ordy = 1'b0;
    a_r = '0; b_r = '0; cin_r = 1'b0; sub_r = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", c_ir, 1);
    chk("rst_busy", c_bz, 0);
    chk("rst_out_valid", c_ov, 0);
    chk("rst_sum", c_sum, 0);
    chk("rst_cout", c_co, 0);
    chk("rst_ovf", c_vf, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 0, 0, rs, rc, rv);
      chk($sformatf("vec%0d_sum", i), rs, tbl[i].s);
      chk($sformatf("vec%0d_cout", i), rc, tbl[i].co);
      chk($sformatf("vec%0d_ovf", i), rv, tbl[i].ov);
    end

    // Back-pressure: result held for 10 cycles while in_valid pulses are ignored.
    a_r = 6; b_r = 7; cin_r = 0; sub_r = 0; iv = 1'b1;
    @(posedge clk); #1 iv = 1'b0;
    n_issued++;
    n = 0;
    while (!c_ov && n < 64) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, 4);
    for (int k = 0; k < 10; k++) begin
      iv = 1'($urandom); a_r = $urandom; b_r = $urandom;
      @(posedge clk); #1;
      chk("bp_out_valid", c_ov, 1);
      chk("bp_sum", c_sum, 13);
      chk("bp_cout", c_co, 0);
      chk("bp_ovf", c_vf, 1);
      chk("bp_in_ready", c_ir, 0);
    end
    iv = 1'b0; ordy = 1'b1;
    @(posedge clk); #1 ordy = 1'b0;
    chk("bp_release_in_ready", c_ir, 1);
    chk("bp_release_out_valid", c_ov, 0);

    // Reset during the second RUN cycle of 9+9 discards the operation.
    a_r = 9; b_r = 9; cin_r = 0; sub_r = 0; iv = 1'b1;
    @(posedge clk); #1 iv = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", c_bz, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_in_ready", c_ir, 1);
    chk("mid_rst_busy", c_bz, 0);
    chk("mid_rst_out_valid", c_ov, 0);
    chk("mid_rst_sum", c_sum, 0);
    chk("mid_rst_cout", c_co, 0);
    chk("mid_rst_ovf", c_vf, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_result", c_ov, 0);
    end
    run_op(1, 1, 0, 0, 0, 0, rs, rc, rv);
    chk("after_rst_sum", rs, 2);
    chk("after_rst_cout", rc, 0);

    // Random regression against the arithmetic reference, both widths.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      w = sel ? 8 : 4;
      for (int k = 0; k < 500; k++) begin
        logic [31:0] ra, rb;
        logic        rcin, rsub;
        ra   = $urandom & ((32'd1 << w) - 1);
        rb   = $urandom & ((32'd1 << w) - 1);
        rcin = 1'($urandom);
        rsub = 1'($urandom);
        ref_model(w, longint'(ra), longint'(rb), rcin, rsub, es, ec, ev);
        run_op(ra, rb, rcin, rsub, $urandom_range(0, 3), $urandom_range(0, 3), rs, rc, rv);
        chk($sformatf("rnd_w%0d_%0d_result", w, k), {31'b0, rc, rs}, {31'b0, ec, es[31:0]});
        chk($sformatf("rnd_w%0d_%0d_ovf", w, k), rv, ev);
      end
    end

    repeat (2) @(posedge clk); #1;
    chk("result_count", n_presented, n_issued);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
